// File: rtl/sfi_pkg.sv
`default_nettype none
// ============================================================================
// sfi_pkg : shared FSM encoding and default constants for sfi_resp_guard
// Revision : 1.0
// ============================================================================
package sfi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_MEM_REQ  = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_RSP      = 3'd4
    } sfi_state_e;

    localparam logic [7:0] C_SBX_TAG_DEF  = 8'hA2;
    localparam logic [7:0] C_SBX_MASK_DEF = 8'hFF;
    localparam int         C_FCNT_W       = 16;

    function automatic logic [C_FCNT_W-1:0] sat_inc(input logic [C_FCNT_W-1:0] v);
        return (&v) ? v : v + {{(C_FCNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfi_region_check.sv
`default_nettype none
// ============================================================================
// sfi_region_check : masked compare of the address region byte against the
//                    sandbox tag; legal=1 when the request stays in-sandbox
// Revision : 1.0
// ============================================================================
module sfi_region_check
    import sfi_pkg::*;
#(
    parameter logic [7:0] SBX_TAG  = C_SBX_TAG_DEF,
    parameter logic [7:0] SBX_MASK = C_SBX_MASK_DEF
) (
    input  logic [7:0] addr_hi,
    output logic       legal
);

    assign legal = ((addr_hi & SBX_MASK) == (SBX_TAG & SBX_MASK));

endmodule
`default_nettype wire

// File: rtl/sfi_resp_guard.sv
`default_nettype none
// ============================================================================
// sfi_resp_guard : sandbox fault-isolation guard between an initiator and
//                  memory. Optional fault counter: SFI_GUARD_FAULT_CNT_EN
// Revision : 1.0
// ============================================================================
module sfi_resp_guard
    import sfi_pkg::*;
#(
    parameter logic [7:0] SBX_TAG  = C_SBX_TAG_DEF,
    parameter logic [7:0] SBX_MASK = C_SBX_MASK_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         req_addr,
    input  logic                req_we,
    input  logic [31:0]         req_wdata,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [31:0]         mem_addr,
    output logic                mem_we,
    output logic [31:0]         mem_wdata,
    input  logic                mem_rvalid,
    input  logic [31:0]         mem_rdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [31:0]         rsp_data,
    output logic                rsp_fault,
    output logic                fault_sticky,
    output logic [31:0]         fault_addr,
`ifdef SFI_GUARD_FAULT_CNT_EN
    output logic [C_FCNT_W-1:0] fault_cnt,
`endif
    input  logic                clr_fault
);

    sfi_state_e  state_q, state_d;
    logic        req_ready_q;
    logic [31:0] addr_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic        mem_valid_q, mem_valid_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_fault_q, rsp_fault_d;
    logic        fault_sticky_q;
    logic [31:0] fault_addr_q;
    logic        w_legal;
    logic        w_accept;
    logic        w_fault_evt;

    sfi_region_check #(
        .SBX_TAG  (SBX_TAG),
        .SBX_MASK (SBX_MASK)
    ) u_region_check (
        .addr_hi (addr_q[31:24]),
        .legal   (w_legal)
    );

    // Valid strobes are registered, so the first cycle in MEM_REQ/RSP only
    // raises the strobe; this gives the fixed two-edge accept-to-valid latency.
    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;
        w_accept    = 1'b0;
        w_fault_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    w_accept = 1'b1;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_legal) begin
                    state_d = ST_MEM_REQ;
                end else begin
                    w_fault_evt = 1'b1;
                    rsp_data_d  = 32'h0;
                    rsp_fault_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end
            ST_MEM_REQ: begin
                if (!mem_valid_q) begin
                    mem_valid_d = 1'b1;
                end else if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    state_d     = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_rvalid) begin
                    rsp_data_d  = we_q ? 32'h0 : mem_rdata;
                    rsp_fault_d = 1'b0;
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            addr_q      <= 32'h0;
            we_q        <= 1'b0;
            wdata_q     <= 32'h0;
            mem_valid_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == ST_IDLE);
            mem_valid_q <= mem_valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
            if (w_accept) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                wdata_q <= req_wdata;
            end
        end
    end

    // A fault recorded on the same edge as a clear takes precedence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_sticky_q <= 1'b0;
            fault_addr_q   <= 32'h0;
        end else begin
            if (w_fault_evt) begin
                fault_sticky_q <= 1'b1;
            end else if (clr_fault) begin
                fault_sticky_q <= 1'b0;
            end
            if (w_fault_evt && (clr_fault || !fault_sticky_q)) begin
                fault_addr_q <= addr_q;
            end else if (clr_fault && !w_fault_evt) begin
                fault_addr_q <= 32'h0;
            end
        end
    end

`ifdef SFI_GUARD_FAULT_CNT_EN
    logic [C_FCNT_W-1:0] fault_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_cnt_q <= '0;
        end else if (w_fault_evt) begin
            fault_cnt_q <= clr_fault ? {{(C_FCNT_W-1){1'b0}}, 1'b1} : sat_inc(fault_cnt_q);
        end else if (clr_fault) begin
            fault_cnt_q <= '0;
        end
    end

    assign fault_cnt = fault_cnt_q;
`endif

    assign req_ready    = req_ready_q;
    assign mem_valid    = mem_valid_q;
    assign mem_addr     = mem_valid_q ? addr_q  : 32'h0;
    assign mem_we       = mem_valid_q & we_q;
    assign mem_wdata    = mem_valid_q ? wdata_q : 32'h0;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_valid_q ? rsp_data_q : 32'h0;
    assign rsp_fault    = rsp_valid_q & rsp_fault_q;
    assign fault_sticky = fault_sticky_q;
    assign fault_addr   = fault_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_sfi_resp_guard.sv
`default_nettype none
// ============================================================================
// tb_sfi_resp_guard : table vectors, corner sequences and randomized traffic
//                     against a rule-level model of the sandbox guard
// Revision : 1.0
// ============================================================================
module tb_sfi_resp_guard;

    localparam logic [7:0] TAG  = 8'hA2;
    localparam logic [7:0] MASK = 8'hFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        rsp_valid, rsp_ready, rsp_fault;
    logic [31:0] rsp_data;
    logic        fault_sticky, clr_fault;
    logic [31:0] fault_addr;
`ifdef SFI_GUARD_FAULT_CNT_EN
    logic [15:0] fault_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic        m_sticky;
    logic [31:0] m_faddr;
    int          m_cnt;

    sfi_resp_guard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_we       (req_we),
        .req_wdata    (req_wdata),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_fault    (rsp_fault),
        .fault_sticky (fault_sticky),
        .fault_addr   (fault_addr),
`ifdef SFI_GUARD_FAULT_CNT_EN
        .fault_cnt    (fault_cnt),
`endif
        .clr_fault    (clr_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          mstall;
        int          rstall;
        logic        exp_fault;
        logic [31:0] exp_data;
        logic        exp_sticky;
        logic [31:0] exp_faddr;
        int          exp_cnt;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic is_legal(input logic [31:0] a);
        return (a[31:24] & MASK) == (TAG & MASK);
    endfunction

    task automatic model_reset();
        m_sticky = 1'b0;
        m_faddr  = 32'h0;
        m_cnt    = 0;
    endtask

    // One request's effect on the fault record: first fault since clear is kept,
    // a clear landing on the check edge loses to a fault but wipes otherwise.
    task automatic model_apply(input logic [31:0] a, input logic clr);
        if (!is_legal(a)) begin
            if (clr || !m_sticky) m_faddr = a;
            m_sticky = 1'b1;
            m_cnt    = clr ? 1 : ((m_cnt < 65535) ? m_cnt + 1 : 65535);
        end else if (clr) begin
            model_reset();
        end
    endtask

    task automatic check_fault(input string tag, input logic s, input logic [31:0] fa, input int c);
        check({tag, "_sticky"}, fault_sticky, s);
        check({tag, "_faddr"}, fault_addr, fa);
`ifdef SFI_GUARD_FAULT_CNT_EN
        check({tag, "_cnt"}, fault_cnt, c);
`else
        if (c < 0) $display("negative count %0d", c);
`endif
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("req_ready_wait", req_ready, 1);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        model_reset();
        check_fault("clear", 1'b0, 32'h0, 0);
    endtask

    task automatic do_txn(input logic [31:0] a, input logic we, input logic [31:0] wd,
                          input logic [31:0] rd, input int mstall, input int rstall,
                          input logic clr_chk, output logic got_fault, output logic [31:0] got_data);
        logic legal;
        int   k;
        legal = is_legal(a);
        wait_ready();
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = we;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_we    = ~we;
        req_wdata = $urandom;
        clr_fault = clr_chk;
        check("busy_ready", req_ready, 0);
        check("lat1_valids", {mem_valid, rsp_valid}, 2'b00);
        @(negedge clk);
        clr_fault = 1'b0;
        check("lat2_valids", {mem_valid, rsp_valid}, 2'b00);
        @(negedge clk);
        if (legal) begin
            for (int i = 0; i <= mstall; i++) begin
                if (i > 0) @(negedge clk);
                check("mem_fields", {mem_addr, mem_wdata}, {a, wd});
                check("mem_ctrl", {mem_valid, mem_we, req_ready, rsp_valid}, {1'b1, we, 1'b0, 1'b0});
            end
            mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0;
            check("mem_idle_fields", {mem_addr, mem_wdata}, 64'h0);
            check("mem_idle_ctrl", {mem_valid, mem_we}, 2'b00);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            mem_rvalid = 1'b1;
            mem_rdata  = rd;
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end else begin
            check("no_mem_txn", mem_valid, 0);
        end
        k = 0;
        while (!rsp_valid && k < 8) begin
            @(negedge clk);
            k++;
        end
        check("rsp_arrive", rsp_valid, 1);
        if (!legal) check("fault_latency", k, 0);
        got_fault = rsp_fault;
        got_data  = rsp_data;
        for (int i = 0; i < rstall; i++) begin
            @(negedge clk);
            check("rsp_hold", {rsp_valid, rsp_fault, rsp_data}, {1'b1, got_fault, got_data});
            check("rsp_busy", {req_ready, mem_valid}, 2'b00);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done", {rsp_valid, req_ready}, 2'b01);
    endtask

    task automatic issue_to_wait(input logic [31:0] a);
        wait_ready();
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("seq_mem_valid", {mem_valid, mem_addr}, {1'b1, a});
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
    endtask

    task automatic quiet_after_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFEEDFACE;
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check({tag, "_no_rsp"}, {rsp_valid, mem_valid}, 2'b00);
        end
        check_fault(tag, 1'b0, 32'h0, 0);
    endtask

    initial begin
        logic        gf;
        logic [31:0] gd;
        logic [31:0] a;
        logic        we, clr;
        logic [31:0] wd, rd;

        tbl[0] = '{32'hA2199872, 1'b0, 32'h0,      32'h12345678, 0, 0, 1'b0, 32'h12345678, 1'b0, 32'h0,      0};
        tbl[1] = '{32'hA2000100, 1'b1, 32'hDEADBEEF, 32'h55555555, 1, 0, 1'b0, 32'h0,      1'b0, 32'h0,      0};
        tbl[2] = '{32'h00FFEEDD, 1'b0, 32'h0,      32'h0,        0, 0, 1'b1, 32'h0,        1'b1, 32'h00FFEEDD, 1};
        tbl[3] = '{32'h11000000, 1'b0, 32'h0,      32'h0,        0, 1, 1'b1, 32'h0,        1'b1, 32'h00FFEEDD, 2};
        tbl[4] = '{32'hA2FFFFFC, 1'b0, 32'h0,      32'hCAFEF00D, 5, 3, 1'b0, 32'hCAFEF00D, 1'b1, 32'h00FFEEDD, 2};
        tbl[5] = '{32'hA3000000, 1'b1, 32'h01020304, 32'h0,      0, 0, 1'b1, 32'h0,        1'b1, 32'h00FFEEDD, 3};

        rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_we = 1'b0; req_wdata = 32'h0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; rsp_ready = 1'b0; clr_fault = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_valids", {mem_valid, rsp_valid, rsp_fault, mem_we}, 4'b0);
        check("rst_mem_fields", {mem_addr, mem_wdata}, 64'h0);
        check("rst_rsp_data", rsp_data, 0);
        check_fault("rst", 1'b0, 32'h0, 0);
        rst_n = 1'b1;
        #1;
        check("release_ready_low", req_ready, 0);
        @(negedge clk);
        check("release_ready_high", req_ready, 1);

        for (int i = 0; i < 6; i++) begin
            do_txn(tbl[i].addr, tbl[i].we, tbl[i].wdata, tbl[i].rdata, tbl[i].mstall, tbl[i].rstall,
                   1'b0, gf, gd);
            model_apply(tbl[i].addr, 1'b0);
            check($sformatf("tbl%0d_fault", i), gf, tbl[i].exp_fault);
            check($sformatf("tbl%0d_data", i), gd, tbl[i].exp_data);
            check_fault($sformatf("tbl%0d", i), tbl[i].exp_sticky, tbl[i].exp_faddr, tbl[i].exp_cnt);
        end

        do_clear();

        do_txn(32'h11000000, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0, gf, gd);
        model_apply(32'h11000000, 1'b0);
        check_fault("prefault", 1'b1, 32'h11000000, 1);
        do_txn(32'h00000004, 1'b0, 32'h0, 32'h0, 0, 0, 1'b1, gf, gd);
        model_apply(32'h00000004, 1'b1);
        check_fault("clr_vs_fault", 1'b1, 32'h00000004, 1);

        issue_to_wait(32'hA2000010);
        #2 rst_n = 1'b0;
        #1;
        check("rst_wait_drop", {mem_valid, rsp_valid, req_ready}, 3'b000);
        quiet_after_reset("rst_wait");

        issue_to_wait(32'hA2000020);
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h99887766;
        @(negedge clk);
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("rsp_before_rst", {rsp_valid, rsp_data}, {1'b1, 32'h99887766});
        #2 rst_n = 1'b0;
        #1;
        check("rst_rsp_drop", {rsp_valid, rsp_fault, rsp_data}, 34'h0);
        quiet_after_reset("rst_rsp");

        do_txn(32'hA2000010, 1'b0, 32'h0, 32'h0BADF00D, 0, 0, 1'b0, gf, gd);
        check("post_rst_txn", {gf, gd}, {1'b0, 32'h0BADF00D});

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) do_clear();
            a   = $urandom;
            if ($urandom_range(0, 1) == 1) a[31:24] = TAG;
            we  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            rd  = $urandom;
            clr = ($urandom_range(0, 7) == 0);
            do_txn(a, we, wd, rd, $urandom_range(0, 3), $urandom_range(0, 3), clr, gf, gd);
            model_apply(a, clr);
            check("rnd_fault", gf, !is_legal(a));
            check("rnd_data", gd, (is_legal(a) && !we) ? rd : 32'h0);
            check_fault("rnd", m_sticky, m_faddr, m_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
